// File: rtl/dmem_bridge_if.sv
// cpu data port and dmem port of the data-side bridge.
// The bridge takes the slave view; the cpu/memory side takes master.
interface dmem_bridge_if #(
  parameter int WORD    = 32,
  parameter int DMEM_AW = 18
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [WORD-1:0]      cpu_addr;
  logic [WORD-1:0]      cpu_wdata;
  logic [WORD/8-1:0]    cpu_be;
  logic [WORD-1:0]      cpu_rdata;
  logic                 cpu_stall;
  logic                 mem_we;
  logic [DMEM_AW-1:0]   mem_addr;
  logic [WORD-1:0]      mem_wdata;
  logic [WORD/8-1:0]    mem_be;
  logic [WORD-1:0]      mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, cpu_be, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_we,
    input  mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, cpu_be, mem_rdata,
    output cpu_rdata, cpu_stall, mem_we,
    output mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-side bridge: RAM wait states with cpu stall, MMIO
// registers (tohost, 64-bit cycle counter) and error decode.
module dmem_bridge #(
  parameter int              WORD      = 32,
  parameter int              DMEM_AW   = 18,
  parameter int              DMEM_LAT  = 0,
  parameter logic [WORD-1:0] MMIO_BASE = WORD'(32'h4000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  dmem_bridge_if.slave     bus,
  output logic [WORD-1:0]  tohost,
  output logic             tohost_valid,
  output logic             err
);

  localparam int NB = WORD / 8;
  localparam bit LAT0 = (DMEM_LAT == 0);
  localparam logic [3:0] LAT_M1 =
    4'(DMEM_LAT > 0 ? DMEM_LAT - 1 : 0);

  typedef enum logic { IDLE, WAIT } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [63:0] cyc;

  logic            aligned, is_ram, is_mmio, is_bad;
  logic            act, done, mmio_wr;
  logic [1:0]      off;
  logic [WORD-1:0] mmio_rd;

  assign aligned = (bus.cpu_addr[1:0] == 2'b00);
  assign is_ram  = aligned &&
    (bus.cpu_addr[WORD-1:DMEM_AW+2] == '0);
  assign is_mmio = aligned &&
    (bus.cpu_addr[WORD-1:4] == MMIO_BASE[WORD-1:4]);
  assign is_bad  = !is_ram && !is_mmio;
  assign off     = bus.cpu_addr[3:2];

  // reset kills an in-flight access at once, even with cpu_req held
  assign act = bus.cpu_req && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (act && is_ram && !LAT0) begin
          state_n = WAIT;
          cnt_n   = LAT_M1;
        end
      end
      WAIT: begin
        if (!act || cnt == 4'd0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    unique case (off)
      2'd0:    mmio_rd = tohost;
      2'd2:    mmio_rd = cyc[WORD-1:0];
      2'd3:    mmio_rd = WORD'(cyc[63:32]);
      default: mmio_rd = '0;
    endcase
  end

  always_comb begin
    done = act && (
      (state == IDLE && (!is_ram || LAT0)) ||
      (state == WAIT && cnt == 4'd0));
    bus.cpu_stall = act && !done;
    bus.mem_we    = done && is_ram && bus.cpu_we;
    bus.mem_addr  = bus.cpu_addr[DMEM_AW+1:2];
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_be    = bus.cpu_be;
    bus.cpu_rdata = '0;
    if (done && is_ram)  bus.cpu_rdata = bus.mem_rdata;
    if (done && is_mmio) bus.cpu_rdata = mmio_rd;
    err     = done && is_bad;
    mmio_wr = done && is_mmio && bus.cpu_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc          <= '0;
      tohost       <= '0;
      tohost_valid <= 1'b0;
    end else begin
      cyc          <= cyc + 64'd1;
      tohost_valid <= mmio_wr && (off == 2'd0);
      if (mmio_wr && off == 2'd0) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.cpu_be[i])
            tohost[8*i +: 8] <= bus.cpu_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench: three bridges (0, 3 and 4 wait states),
// each with its own small RAM model.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  logic [31:0] rdata [3];
  logic [31:0] th    [3];
  logic [2:0]  stall, mwe, tv, er;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 3 : 4;
    logic [31:0] ram [256];

    dmem_bridge_if #(.WORD(32), .DMEM_AW(18)) bus ();

    assign bus.cpu_req   = req[g];
    assign bus.cpu_we    = we;
    assign bus.cpu_addr  = addr;
    assign bus.cpu_wdata = wdata;
    assign bus.cpu_be    = be;
    assign bus.mem_rdata = ram[bus.mem_addr[7:0]];
    assign rdata[g]      = bus.cpu_rdata;
    assign stall[g]      = bus.cpu_stall;
    assign mwe[g]        = bus.mem_we;

    always @(posedge clk) begin
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.mem_be[i])
            ram[bus.mem_addr[7:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end

    dmem_bridge #(
      .WORD(32), .DMEM_AW(18), .DMEM_LAT(L),
      .MMIO_BASE(32'h4000_0000)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.slave),
      .tohost       (th[g]),
      .tohost_valid (tv[g]),
      .err          (er[g])
    );
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic issue(int d, logic w, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] b);
    @(negedge clk);
    req    = '0;
    req[d] = 1'b1;
    we     = w;
    addr   = a;
    wdata  = wd;
    be     = b;
    #2;
  endtask

  task automatic idle();
    @(negedge clk);
    req = '0;
    #2;
  endtask

  // counts stalled cycles; returns sampled in the completing cycle
  task automatic run(int d, output int ns, output int nw);
    ns = 0;
    nw = 0;
    while (stall[d] && ns < 32) begin
      nw += int'(mwe[d]);
      ns++;
      @(negedge clk);
      #2;
    end
    nw += int'(mwe[d]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 1 exp 0");
    $fatal(1);
  end

  initial begin
    int ns, nw;
    logic [31:0] c1, c2;

    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_stall", {61'd0, stall}, 64'd0);
    check("rst_mwe", {61'd0, mwe}, 64'd0);
    check("rst_tv", {61'd0, tv}, 64'd0);
    check("rst_err", {61'd0, er}, 64'd0);
    check("rst_rdata", rdata[0], 64'd0);
    check("rst_tohost", th[0], 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // T1: zero wait states
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    check("t1_st_stall", stall[0], 0);
    check("t1_st_we", mwe[0], 1);
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    check("t1_ld_stall", stall[0], 0);
    check("t1_ld_we", mwe[0], 0);
    check("t1_ld_data", rdata[0], 32'hDEADBEEF);
    idle();
    check("t1_idle_rdata", rdata[0], 0);

    // T2: three wait states
    issue(1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    run(1, ns, nw);
    idle();
    nw += int'(mwe[1]);
    check("t2_st_stalls", ns, 3);
    check("t2_st_we_cycles", nw, 1);
    issue(1, 1'b0, 32'h40, 32'h0, 4'hF);
    check("t2_ld_stall0", stall[1], 1);
    check("t2_ld_rd_early", rdata[1], 0);
    run(1, ns, nw);
    check("t2_ld_stalls", ns, 3);
    check("t2_ld_data", rdata[1], 32'h12345678);
    idle();
    check("t2_after_stall", stall[1], 0);

    // T3: MMIO
    issue(0, 1'b1, 32'h4000_0000, 32'hFFFFFF11, 4'h1);
    check("t3_no_stall", stall[0], 0);
    check("t3_no_memwe", mwe[0], 0);
    check("t3_tv_early", tv[0], 0);
    idle();
    check("t3_tv_pulse", tv[0], 1);
    check("t3_tohost", th[0], 32'h11);
    idle();
    check("t3_tv_end", tv[0], 0);
    issue(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
    check("t3_rd_tohost", rdata[0], 32'h11);
    issue(0, 1'b0, 32'h4000_0004, 32'h0, 4'hF);
    check("t3_rd_rsvd", rdata[0], 0);
    issue(0, 1'b0, 32'h4000_0008, 32'h0, 4'hF);
    c1 = rdata[0];
    for (int i = 0; i < 6; i++) idle();
    issue(0, 1'b0, 32'h4000_0008, 32'h0, 4'hF);
    c2 = rdata[0];
    check("t3_cyc_delta", c2 - c1, 7);
    issue(0, 1'b0, 32'h4000_000C, 32'h0, 4'hF);
    check("t3_cyc_high", rdata[0], 0);

    // T4: bad accesses
    issue(0, 1'b0, 32'h7FFF_FFF0, 32'h0, 4'hF);
    check("t4_ld_err", er[0], 1);
    check("t4_ld_rdata", rdata[0], 0);
    issue(0, 1'b1, 32'h102, 32'hFFFFFFFF, 4'hF);
    check("t4_st_err", er[0], 1);
    check("t4_st_we", mwe[0], 0);
    issue(1, 1'b0, 32'h7FFF_FFF0, 32'h0, 4'hF);
    check("t4_lat_nostall", stall[1], 0);
    check("t4_lat_err", er[1], 1);
    idle();
    check("t4_err_end", er[1], 0);
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    check("t4_ram_kept", rdata[0], 32'hDEADBEEF);

    // T6: byte enables
    issue(0, 1'b1, 32'h0, 32'h0, 4'hF);
    issue(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0100);
    issue(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000);
    check("t6_be0_done", stall[0], 0);
    issue(0, 1'b0, 32'h0, 32'h0, 4'hF);
    check("t6_lane", rdata[0], 32'h00BB0000);

    // T5: reset in WAIT during a store
    issue(2, 1'b1, 32'h200, 32'h5555AAAA, 4'hF);
    run(2, ns, nw);
    check("t5_pre_stalls", ns, 4);
    issue(2, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("t5_rst_stall", stall[2], 0);
    check("t5_rst_we", mwe[2], 0);
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    #2;
    check("t5_ram_kept", g_dut[2].ram[128], 32'h5555AAAA);
    check("t5_tohost_clr", th[0], 0);
    issue(2, 1'b0, 32'h200, 32'h0, 4'hF);
    run(2, ns, nw);
    check("t5_post_stalls", ns, 4);
    check("t5_post_data", rdata[2], 32'h5555AAAA);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
